// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshake, tag passthrough and flush.
// Define ALU_BITMANIP_EN to enable CTZ/CLZ/CPOP/ROL/ROR/MIN/MAX/MINU/MAXU/ANDN.
module alu_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic             s1_valid_q;
  logic [4:0]       s1_op_q;
  logic [XLEN-1:0]  s1_a_q, s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [XLEN-1:0]  s2_result_q;
  logic             s2_illegal_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             s1_load, s2_load;
  logic [XLEN-1:0]  result_d;
  logic             illegal_d;
  logic [ShW-1:0]   shamt;
`ifdef ALU_BITMANIP_EN
  logic [2*XLEN-1:0] rot;
`endif

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = !rst && !flush && (!s1_valid_q || !s2_valid_q || out_ready);
  assign shamt    = s1_b_q[ShW-1:0];

  always_comb begin
    result_d  = '0;
    illegal_d = 1'b0;
`ifdef ALU_BITMANIP_EN
    rot       = '0;
`endif
    case (s1_op_q)
      5'b00000: result_d = s1_a_q + s1_b_q;
      5'b01000: result_d = s1_a_q - s1_b_q;
      5'b00001: result_d = s1_a_q << shamt;
      5'b00010: result_d = {{(XLEN-1){1'b0}}, $signed(s1_a_q) < $signed(s1_b_q)};
      5'b00011: result_d = {{(XLEN-1){1'b0}}, s1_a_q < s1_b_q};
      5'b00100: result_d = s1_a_q ^ s1_b_q;
      5'b00101: result_d = s1_a_q >> shamt;
      5'b01101: result_d = $signed(s1_a_q) >>> shamt;
      5'b00110: result_d = s1_a_q | s1_b_q;
      5'b00111: result_d = s1_a_q & s1_b_q;
`ifdef ALU_BITMANIP_EN
      5'b01001: begin
        result_d = XLEN'(XLEN);
        for (int i = int'(XLEN) - 1; i >= 0; i--) begin
          if (s1_a_q[i]) result_d = XLEN'(i);
        end
      end
      5'b01010: begin
        result_d = XLEN'(XLEN);
        for (int i = 0; i < int'(XLEN); i++) begin
          if (s1_a_q[i]) result_d = XLEN'(int'(XLEN) - 1 - i);
        end
      end
      5'b01011: begin
        for (int i = 0; i < int'(XLEN); i++) result_d = result_d + XLEN'(s1_a_q[i]);
      end
      // Rotates shift a doubled operand so no special case is needed for a zero amount.
      5'b10000: begin
        rot      = {s1_a_q, s1_a_q} << shamt;
        result_d = rot[2*XLEN-1:XLEN];
      end
      5'b10001: begin
        rot      = {s1_a_q, s1_a_q} >> shamt;
        result_d = rot[XLEN-1:0];
      end
      5'b10010: result_d = ($signed(s1_a_q) < $signed(s1_b_q)) ? s1_a_q : s1_b_q;
      5'b10011: result_d = ($signed(s1_a_q) < $signed(s1_b_q)) ? s1_b_q : s1_a_q;
      5'b10100: result_d = (s1_a_q < s1_b_q) ? s1_a_q : s1_b_q;
      5'b10101: result_d = (s1_a_q < s1_b_q) ? s1_b_q : s1_a_q;
      5'b10110: result_d = s1_a_q & ~s1_b_q;
`endif
      default:  illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_illegal_q <= 1'b0;
      s2_tag_q     <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_result_q  <= result_d;
          s2_illegal_q <= illegal_d;
          s2_tag_q     <= s1_tag_q;
        end
      end
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_op_q  <= in_op;
          s1_a_q   <= in_a;
          s1_b_q   <= in_b;
          s1_tag_q <= in_tag;
        end
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_tag     = s2_tag_q;
  assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: lane 0 is XLEN=32, lane 1 is XLEN=64; queue-based reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_s[2], iv[2], ordy[2];
  logic [4:0]  op_s[2];
  logic [63:0] a_s[2], b_s[2];
  logic [5:0]  tag_s[2];

  logic        ir0, ov0, ill0, ir1, ov1, ill1;
  logic [31:0] res0;
  logic [63:0] res1;
  logic [5:0]  otag0, otag1;

  logic        ir[2], ov[2], ill[2];
  logic [63:0] res[2];
  logic [5:0]  otag[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference scoreboard: in-flight ops in acceptance order, with the edge each was accepted.
  logic [63:0] q_res[2][8];
  logic        q_ill[2][8];
  logic [5:0]  q_tag[2][8];
  int          q_when[2][8];
  int          q_head[2], q_cnt[2];
  // Transfer and acceptance logs for directed literal checks.
  logic [63:0] g_res[2][32];
  logic [5:0]  g_tag[2][32];
  logic        g_ill[2][32];
  int          g_cyc[2][32], a_cyc[2][32];
  int          n_got[2], n_acc[2];

  always #5 clk = ~clk;

  alu_pipe #(.XLEN(32), .TAG_W(6)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush_s[0]), .in_valid(iv[0]), .in_ready(ir0),
    .in_op(op_s[0]), .in_a(a_s[0][31:0]), .in_b(b_s[0][31:0]), .in_tag(tag_s[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .out_result(res0), .out_tag(otag0),
    .out_illegal(ill0)
  );

  alu_pipe #(.XLEN(64), .TAG_W(6)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush_s[1]), .in_valid(iv[1]), .in_ready(ir1),
    .in_op(op_s[1]), .in_a(a_s[1]), .in_b(b_s[1]), .in_tag(tag_s[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .out_result(res1), .out_tag(otag1),
    .out_illegal(ill1)
  );

  always_comb begin
    ir[0] = ir0;  ov[0] = ov0;  ill[0] = ill0;  res[0] = {32'h0, res0};  otag[0] = otag0;
    ir[1] = ir1;  ov[1] = ov1;  ill[1] = ill1;  res[1] = res1;           otag[1] = otag1;
  end

  // Returns {illegal, result} for width w straight from the operation definitions.
  function automatic logic [64:0] ref_alu(input logic [4:0] op, input logic [63:0] ai,
                                          input logic [63:0] bi, input int w);
    logic [63:0] m, a, b, r;
    logic signed [63:0] sa, sb;
    int sh, c;
    logic il;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a  = ai & m;
    b  = bi & m;
    sa = (w == 64) ? a : {{32{a[31]}}, a[31:0]};
    sb = (w == 64) ? b : {{32{b[31]}}, b[31:0]};
    sh = int'(b[5:0]) % w;
    r  = 64'h0;
    il = 1'b0;
    case (op)
      5'b00000: r = a + b;
      5'b01000: r = a - b;
      5'b00001: r = a << sh;
      5'b00010: r = (sa < sb) ? 64'd1 : 64'd0;
      5'b00011: r = (a < b) ? 64'd1 : 64'd0;
      5'b00100: r = a ^ b;
      5'b00101: r = a >> sh;
      5'b01101: r = sa >>> sh;
      5'b00110: r = a | b;
      5'b00111: r = a & b;
`ifdef ALU_BITMANIP_EN
      5'b01001: begin c = w; for (int i = w - 1; i >= 0; i--) if (a[i]) c = i; r = 64'(c); end
      5'b01010: begin c = w; for (int i = 0; i < w; i++) if (a[i]) c = w - 1 - i; r = 64'(c); end
      5'b01011: begin c = 0; for (int i = 0; i < w; i++) if (a[i]) c++; r = 64'(c); end
      5'b10000: r = (sh == 0) ? a : ((a << sh) | (a >> (w - sh)));
      5'b10001: r = (sh == 0) ? a : ((a >> sh) | (a << (w - sh)));
      5'b10010: r = (sa < sb) ? a : b;
      5'b10011: r = (sa < sb) ? b : a;
      5'b10100: r = (a < b) ? a : b;
      5'b10101: r = (a < b) ? b : a;
      5'b10110: r = a & ~b;
`endif
      default:  il = 1'b1;
    endcase
    r = il ? 64'h0 : (r & m);
    return {il, r};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      for (int l = 0; l < 2; l++) begin
        int hd, w, idx;
        logic vis;
        logic [64:0] m;
        w   = (l == 0) ? 32 : 64;
        hd  = q_head[l];
        vis = (q_cnt[l] > 0) && (q_when[l][hd] < cyc);
        check($sformatf("l%0d in_ready", l), 64'(ir[l]),
              64'(!rst && !flush_s[l] && (q_cnt[l] < 2 || ordy[l])));
        check($sformatf("l%0d out_valid", l), 64'(ov[l]), 64'(vis));
        if (vis && ov[l]) begin
          check($sformatf("l%0d out_result", l), res[l], q_res[l][hd]);
          check($sformatf("l%0d out_tag", l), 64'(otag[l]), 64'(q_tag[l][hd]));
          check($sformatf("l%0d out_illegal", l), 64'(ill[l]), 64'(q_ill[l][hd]));
        end
        if (rst || flush_s[l]) begin
          q_cnt[l]  = 0;
          q_head[l] = 0;
        end else begin
          if (ov[l] && ordy[l]) begin
            if (n_got[l] < 32) begin
              g_res[l][n_got[l]] = res[l];
              g_tag[l][n_got[l]] = otag[l];
              g_ill[l][n_got[l]] = ill[l];
              g_cyc[l][n_got[l]] = cyc + 1;
            end
            n_got[l]++;
            if (vis) begin
              q_head[l] = (q_head[l] + 1) % 8;
              q_cnt[l]--;
            end
          end
          if (iv[l] && ir[l] && q_cnt[l] < 8) begin
            idx = (q_head[l] + q_cnt[l]) % 8;
            m   = ref_alu(op_s[l], a_s[l], b_s[l], w);
            q_res[l][idx]  = m[63:0];
            q_ill[l][idx]  = m[64];
            q_tag[l][idx]  = tag_s[l];
            q_when[l][idx] = cyc + 1;
            q_cnt[l]++;
            if (n_acc[l] < 32) a_cyc[l][n_acc[l]] = cyc + 1;
            n_acc[l]++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op and holds it until accepted (bounded); leaves in_valid high on return.
  task automatic send(input int l, input logic [4:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [5:0] tag);
    logic done;
    iv[l] = 1'b1; op_s[l] = op; a_s[l] = a; b_s[l] = b; tag_s[l] = tag;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (ir[l]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL l%0d send timeout: tag %0d not accepted within 20 cycles", l, tag);
      iv[l] = 1'b0;
    end
  endtask

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(5))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h1 << $urandom_range(63);
      3:       return 64'($urandom_range(70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  logic [4:0]  legal_ops[20];
  logic [4:0]  t_op[7];
  logic [63:0] t_a[7], t_b[7], t_r[7];
  logic        t_il[7];
  int          b0, a0, nt;

  initial begin
    legal_ops = '{5'h00, 5'h08, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h0D, 5'h06, 5'h07,
                  5'h09, 5'h0A, 5'h0B, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16};
    for (int l = 0; l < 2; l++) begin
      flush_s[l] = 0; iv[l] = 0; ordy[l] = 1; op_s[l] = 0; a_s[l] = 0; b_s[l] = 0;
      tag_s[l] = 0; q_head[l] = 0; q_cnt[l] = 0; n_got[l] = 0; n_acc[l] = 0;
    end
    rst = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) tick();
    check("reset out_valid", 64'(ov0), 64'h0);
    check("reset out_result", 64'(res0), 64'h0);
    check("reset out_tag", 64'(otag0), 64'h0);
    check("reset out_illegal", 64'(ill0), 64'h0);
    rst = 1'b0;

    // Stream with out_ready held high
    b0 = n_got[0]; a0 = n_acc[0];
    send(0, 5'b00000, 64'd7, 64'd5, 6'd1);
    send(0, 5'b01000, 64'd3, 64'd5, 6'd2);
    send(0, 5'b01101, 64'h8000_0000, 64'd4, 6'd3);
    iv[0] = 1'b0;
    repeat (4) tick();
    check("stream res0", g_res[0][b0], 64'd12);
    check("stream tag0", 64'(g_tag[0][b0]), 64'd1);
    check("stream res1", g_res[0][b0+1], 64'hFFFF_FFFE);
    check("stream tag1", 64'(g_tag[0][b0+1]), 64'd2);
    check("stream res2", g_res[0][b0+2], 64'hF800_0000);
    check("stream tag2", 64'(g_tag[0][b0+2]), 64'd3);
    check("stream latency", 64'(g_cyc[0][b0]), 64'(a_cyc[0][a0] + 2));
    check("stream back2back", 64'(g_cyc[0][b0+2]), 64'(g_cyc[0][b0] + 2));

    // Backpressure: capacity two, third held until out_ready returns
    ordy[0] = 1'b0;
    b0 = n_got[0]; a0 = n_acc[0];
    send(0, 5'b00000, 64'd1, 64'd1, 6'd4);
    send(0, 5'b00000, 64'd2, 64'd2, 6'd5);
    op_s[0] = 5'b00000; a_s[0] = 64'd3; b_s[0] = 64'd3; tag_s[0] = 6'd6; iv[0] = 1'b1;
    repeat (5) tick();
    check("bp accepted while full", 64'(n_acc[0] - a0), 64'd2);
    ordy[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    check("bp accepted after release", 64'(n_acc[0] - a0), 64'd3);
    check("bp third on drain edge", 64'(a_cyc[0][a0+2]), 64'(g_cyc[0][b0]));
    check("bp order tag0", 64'(g_tag[0][b0]), 64'd4);
    check("bp order tag2", 64'(g_tag[0][b0+2]), 64'd6);
    check("bp res2", g_res[0][b0+2], 64'd6);

    // Flush with two in flight and an op offered in the flush cycle
    ordy[0] = 1'b0;
    a0 = n_acc[0];
    send(0, 5'b00100, 64'hF0, 64'h0F, 6'd7);
    send(0, 5'b00110, 64'hF0, 64'h0F, 6'd8);
    op_s[0] = 5'b00000; tag_s[0] = 6'd9; iv[0] = 1'b1; flush_s[0] = 1'b1; ordy[0] = 1'b1;
    tick();
    flush_s[0] = 1'b0; iv[0] = 1'b0;
    check("flush no accept", 64'(n_acc[0] - a0), 64'd2);
    b0 = n_got[0];
    send(0, 5'b00000, 64'd10, 64'd10, 6'd10);
    iv[0] = 1'b0;
    repeat (4) tick();
    check("flush only new result", 64'(n_got[0] - b0), 64'd1);
    check("flush new tag", 64'(g_tag[0][b0]), 64'd10);
    check("flush new res", g_res[0][b0], 64'd20);

    // Mid-stream reset
    ordy[0] = 1'b0;
    send(0, 5'b00000, 64'd5, 64'd6, 6'd11);
    send(0, 5'b00000, 64'd7, 64'd8, 6'd12);
    iv[0] = 1'b0; rst = 1'b1;
    tick();
    check("rst out_valid", 64'(ov0), 64'h0);
    check("rst out_result", 64'(res0), 64'h0);
    check("rst out_tag", 64'(otag0), 64'h0);
    rst = 1'b0; ordy[0] = 1'b1;
    b0 = n_got[0];
    repeat (5) tick();
    check("rst no stale result", 64'(n_got[0] - b0), 64'd0);

    // Bitmanip / illegal on the 64-bit lane
`ifdef ALU_BITMANIP_EN
    nt = 7;
    t_op = '{5'b01010, 5'b01001, 5'b01011, 5'b10001, 5'b10010, 5'b10100, 5'b11111};
    t_a  = '{64'h0, 64'h8, 64'hFF00_FF00_FF00_FF00, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 64'd3};
    t_b  = '{64'h0, 64'h0, 64'h0, 64'h1, 64'h1, 64'h1, 64'd4};
    t_r  = '{64'd64, 64'd3, 64'd32, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd1, 64'h0};
    t_il = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    nt = 3;
    t_op = '{5'b01011, 5'b00000, 5'b11111, 5'b0, 5'b0, 5'b0, 5'b0};
    t_a  = '{64'hF, 64'd2, 64'd3, 64'h0, 64'h0, 64'h0, 64'h0};
    t_b  = '{64'h0, 64'd3, 64'd4, 64'h0, 64'h0, 64'h0, 64'h0};
    t_r  = '{64'h0, 64'd5, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    t_il = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    b0 = n_got[1];
    for (int i = 0; i < nt; i++) send(1, t_op[i], t_a[i], t_b[i], 6'(20 + i));
    iv[1] = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < nt; i++) begin
      check($sformatf("lit%0d op %b result", i, t_op[i]), g_res[1][b0+i], t_r[i]);
      check($sformatf("lit%0d op %b illegal", i, t_op[i]), 64'(g_ill[1][b0+i]), 64'(t_il[i]));
    end

    // Randomised traffic on both lanes
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < 2; l++) begin
        iv[l]      = ($urandom_range(3) != 0);
        op_s[l]    = ($urandom_range(7) == 0) ? 5'($urandom) : legal_ops[$urandom_range(19)];
        a_s[l]     = rnd_opnd();
        b_s[l]     = rnd_opnd();
        tag_s[l]   = 6'($urandom);
        ordy[l]    = ($urandom_range(3) != 0);
        flush_s[l] = ($urandom_range(39) == 0);
      end
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0;
    for (int l = 0; l < 2; l++) begin
      iv[l] = 1'b0; ordy[l] = 1'b1; flush_s[l] = 1'b0;
    end
    repeat (5) tick();
    check("drain lane0", 64'(q_cnt[0]), 64'd0);
    check("drain lane1", 64'(q_cnt[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
